// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) round-robin arbiter in front of a
// single-transaction memory. One transaction in flight; the memory signals
// completion with i_mem_fin, and a stalled memory is aborted after TIMEOUT_CYC
// busy cycles with an error response to the granted port.
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    input  logic [2:0]  i_if_sel,
    output logic [31:0] o_if_rdata,
    output logic        o_if_ack,
    output logic        o_if_err,
    input  logic        i_d_req,
    input  logic        i_d_we,
    input  logic [31:0] i_d_addr,
    input  logic [31:0] i_d_wdata,
    input  logic [2:0]  i_d_sel,
    output logic [31:0] o_d_rdata,
    output logic        o_d_ack,
    output logic        o_d_err,
    output logic        o_mem_exec,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_data,
    output logic [2:0]  o_mem_sel,
    input  logic [31:0] i_mem_data,
    input  logic        i_mem_fin,
    output logic        o_grant_d
);

    localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_d_q, last_d_d;
    logic          grant_d_q, grant_d_d;
    logic          exec_q, exec_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic [2:0]    sel_q, sel_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic          if_ack_q, if_ack_d;
    logic          if_err_q, if_err_d;
    logic [31:0]   d_rdata_q, d_rdata_d;
    logic          d_ack_q, d_ack_d;
    logic          d_err_q, d_err_d;
    logic          take;
    logic          pick_d;

    // Next-state and registered-output computation for the arbiter FSM.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d_d   = last_d_q;
        grant_d_d  = grant_d_q;
        exec_d     = exec_q;
        we_d       = we_q;
        addr_d     = addr_q;
        data_d     = data_q;
        sel_d      = sel_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_ack_d   = 1'b0;
        if_err_d   = 1'b0;
        d_ack_d    = 1'b0;
        d_err_d    = 1'b0;
        take       = 1'b0;
        // Data wins unless fetch is also requesting and data won last time.
        pick_d     = i_d_req & (~i_if_req | ~last_d_q);

        case (state_q)
            S_IDLE: begin
                exec_d    = 1'b0;
                grant_d_d = 1'b0;
                take      = i_if_req | i_d_req;
            end
            S_BUSY: begin
                if (i_mem_fin) begin
                    state_d = S_RESP;
                    if (grant_d_q) begin
                        d_ack_d = 1'b1;
                        // Stores keep the previous read data.
                        if (!we_q) begin
                            d_rdata_d = i_mem_data;
                        end
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = i_mem_data;
                    end
                end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    state_d   = S_IDLE;
                    exec_d    = 1'b0;
                    grant_d_d = 1'b0;
                    if (grant_d_q) begin
                        d_ack_d   = 1'b1;
                        d_err_d   = 1'b1;
                        d_rdata_d = '0;
                    end else begin
                        if_ack_d   = 1'b1;
                        if_err_d   = 1'b1;
                        if_rdata_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                // One extra exec cycle lets memory drop fin; a pending request
                // is granted here directly so back-to-back costs 4 cycles.
                state_d   = S_IDLE;
                exec_d    = 1'b0;
                grant_d_d = 1'b0;
                take      = i_if_req | i_d_req;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (take) begin
            state_d   = S_BUSY;
            exec_d    = 1'b1;
            cnt_d     = '0;
            grant_d_d = pick_d;
            last_d_d  = pick_d;
            we_d      = pick_d & i_d_we;
            addr_d    = pick_d ? i_d_addr : i_if_addr;
            data_d    = pick_d ? i_d_wdata : '0;
            sel_d     = pick_d ? i_d_sel : i_if_sel;
        end
    end

    // State and output registers; reset forces idle with everything cleared.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            last_d_q   <= 1'b0;
            grant_d_q  <= 1'b0;
            exec_q     <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            sel_q      <= '0;
            if_rdata_q <= '0;
            if_ack_q   <= 1'b0;
            if_err_q   <= 1'b0;
            d_rdata_q  <= '0;
            d_ack_q    <= 1'b0;
            d_err_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_d_q   <= last_d_d;
            grant_d_q  <= grant_d_d;
            exec_q     <= exec_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            sel_q      <= sel_d;
            if_rdata_q <= if_rdata_d;
            if_ack_q   <= if_ack_d;
            if_err_q   <= if_err_d;
            d_rdata_q  <= d_rdata_d;
            d_ack_q    <= d_ack_d;
            d_err_q    <= d_err_d;
        end
    end

    assign o_mem_exec = exec_q;
    assign o_mem_we   = we_q;
    assign o_mem_addr = addr_q;
    assign o_mem_data = data_q;
    assign o_mem_sel  = sel_q;
    assign o_if_rdata = if_rdata_q;
    assign o_if_ack   = if_ack_q;
    assign o_if_err   = if_err_q;
    assign o_d_rdata  = d_rdata_q;
    assign o_d_ack    = d_ack_q;
    assign o_d_err    = d_err_q;
    assign o_grant_d  = grant_d_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: scripted cycle table, hand-written tie / timeout /
// reset sequences, then randomized traffic against a memory model and a
// transaction-level reference.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_if_req, i_d_req, i_d_we;
    logic [31:0] i_if_addr, i_d_addr, i_d_wdata;
    logic [2:0]  i_if_sel, i_d_sel;
    logic [31:0] o_if_rdata, o_d_rdata, o_mem_addr, o_mem_data;
    logic        o_if_ack, o_if_err, o_d_ack, o_d_err;
    logic        o_mem_exec, o_mem_we, o_grant_d;
    logic [2:0]  o_mem_sel;
    logic [31:0] i_mem_data;
    logic        i_mem_fin;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT_CYC(16)) dut (
        .i_clk(clk), .i_reset_n(i_reset_n),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr), .i_if_sel(i_if_sel),
        .o_if_rdata(o_if_rdata), .o_if_ack(o_if_ack), .o_if_err(o_if_err),
        .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_addr(i_d_addr),
        .i_d_wdata(i_d_wdata), .i_d_sel(i_d_sel),
        .o_d_rdata(o_d_rdata), .o_d_ack(o_d_ack), .o_d_err(o_d_err),
        .o_mem_exec(o_mem_exec), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_data(o_mem_data), .o_mem_sel(o_mem_sel),
        .i_mem_data(i_mem_data), .i_mem_fin(i_mem_fin), .o_grant_d(o_grant_d)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- memory model ----------------
    logic        tb_fin = 1'b0;
    logic [31:0] tb_mdata = '0;
    logic        mem_en = 1'b0, mem_dead = 1'b0, mem_lat_rand = 1'b0, mon_en = 1'b0;
    logic        mm_fin = 1'b0, fin_prev;
    logic [31:0] mm_data = '0;
    int          mm_cnt = 0, mm_lat = 3;
    logic [3:0]  idx;
    logic [31:0] mem_arr [16];
    logic [31:0] ref_arr [16];
    logic [31:0] rec_addr, rec_data;
    logic        rec_we;
    logic [2:0]  rec_sel;

    assign i_mem_fin  = mem_en ? mm_fin  : tb_fin;
    assign i_mem_data = mem_en ? mm_data : tb_mdata;

    function automatic logic [31:0] init_word(input int i);
        return 32'hA500_0000 + 32'(i) * 32'h0001_0203;
    endfunction

    // Memory: raises fin for one cycle mm_lat cycles into a request, drops it
    // while exec is still held, and checks that an ack follows every fin.
    always @(negedge clk) begin
        if (mem_en) begin
            fin_prev = mm_fin;
            if (mon_en) begin
                chk("ack_follows_fin", 32'(o_if_ack) + 32'(o_d_ack), 32'(fin_prev));
                chk("err_low", {30'd0, o_if_err, o_d_err}, 32'd0);
            end
            if (!o_mem_exec) begin
                mm_cnt = 0;
                mm_fin = 1'b0;
            end else if (mm_fin) begin
                mm_fin = 1'b0;
                mm_cnt = 0;
            end else begin
                mm_cnt++;
                if (!mem_dead && mm_cnt == mm_lat) begin
                    mm_fin   = 1'b1;
                    idx      = o_mem_addr[5:2];
                    rec_addr = o_mem_addr;
                    rec_we   = o_mem_we;
                    rec_data = o_mem_data;
                    rec_sel  = o_mem_sel;
                    if (o_mem_we) begin
                        mem_arr[idx] = o_mem_data;
                        mm_data = 32'hBADC_0FFE;
                    end else begin
                        mm_data = mem_arr[idx];
                    end
                    mm_lat = mem_lat_rand ? int'($urandom_range(1, 5)) : 3;
                end
            end
        end
    end

    // ---------------- cycle table ----------------
    typedef struct {
        logic        if_req, d_req, fin;
        logic [31:0] mdata;
        logic        exec, mwe;
        logic [31:0] maddr, mdat;
        logic [2:0]  msel;
        logic        if_ack;
        logic [31:0] if_rd;
        logic        d_ack, d_err;
        logic [31:0] d_rd;
        logic        gd;
    } vec_t;

    function automatic vec_t mk(input logic ir, dr, fn, input logic [31:0] md,
                                input logic ex, mwe, input logic [31:0] ma, mdt,
                                input logic [2:0] ms, input logic ia, input logic [31:0] ird,
                                input logic da, de, input logic [31:0] drd, input logic gd);
        vec_t v;
        v.if_req = ir; v.d_req = dr; v.fin = fn; v.mdata = md;
        v.exec = ex; v.mwe = mwe; v.maddr = ma; v.mdat = mdt; v.msel = ms;
        v.if_ack = ia; v.if_rd = ird; v.d_ack = da; v.d_err = de; v.d_rd = drd; v.gd = gd;
        return v;
    endfunction

    vec_t tbl [11];

    task automatic do_reset();
        @(negedge clk);
        i_reset_n = 1'b0;
        i_if_req = 1'b0; i_d_req = 1'b0; tb_fin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        i_reset_n = 1'b1;
    endtask

    // ---------------- random requesters ----------------
    logic        pend [2];
    int          idle_c [2], wait_c [2], n_done [2];
    logic [31:0] r_addr [2], r_wdata [2], last_rd [2];
    logic        r_we [2];
    logic [2:0]  r_sel [2];

    task automatic new_req(input int p);
        pend[p]    = 1'b1;
        r_addr[p]  = 32'h100 + 32'($urandom_range(0, 15)) * 4;
        r_we[p]    = (p == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        r_wdata[p] = $urandom;
        r_sel[p]   = 3'($urandom_range(0, 7));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, %0d vectors, %0d miscompares", n_vec, n_err);
        $fatal(1);
    end

    initial begin
        int t0, ackc, got;
        logic ex15, a_err, a_ex;
        logic [31:0] a_rd;
        int   a_cyc [4];
        logic a_port [4], a_gd [4];
        logic [31:0] a_rdv [4];
        logic seen_exec;
        logic ack [2];
        logic [31:0] rdv, exp_rd;

        for (int i = 0; i < 16; i++) begin
            mem_arr[i] = init_word(i);
            ref_arr[i] = init_word(i);
        end
        i_if_req = 0; i_d_req = 0; i_d_we = 0;
        i_if_addr = '0; i_d_addr = '0; i_d_wdata = '0; i_if_sel = '0; i_d_sel = '0;

        //            ir dr fn mdata          ex we addr   mdata  sel  ia if_rd          da de d_rd gd
        tbl[0]  = mk(1, 0, 0, 32'h0,        1, 0, 32'h10, 32'h0,  3'b010, 0, 32'h0,        0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 32'h0,        1, 0, 32'h10, 32'h0,  3'b010, 0, 32'h0,        0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 32'h0,        1, 0, 32'h10, 32'h0,  3'b010, 0, 32'h0,        0, 0, 0, 0);
        tbl[3]  = mk(0, 0, 1, 32'hDEADBEEF, 1, 0, 32'h10, 32'h0,  3'b010, 1, 32'hDEADBEEF, 0, 0, 0, 0);
        tbl[4]  = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,  32'h0,  3'b000, 0, 32'hDEADBEEF, 0, 0, 0, 0);
        tbl[5]  = mk(0, 0, 1, 32'hCAFEF00D, 0, 0, 32'h0,  32'h0,  3'b000, 0, 32'hDEADBEEF, 0, 0, 0, 0);
        tbl[6]  = mk(0, 1, 0, 32'h0,        1, 1, 32'h20, 32'hAB, 3'b000, 0, 32'hDEADBEEF, 0, 0, 0, 1);
        tbl[7]  = mk(0, 0, 0, 32'h0,        1, 1, 32'h20, 32'hAB, 3'b000, 0, 32'hDEADBEEF, 0, 0, 0, 1);
        tbl[8]  = mk(0, 0, 0, 32'h0,        1, 1, 32'h20, 32'hAB, 3'b000, 0, 32'hDEADBEEF, 0, 0, 0, 1);
        tbl[9]  = mk(0, 0, 1, 32'h12345678, 1, 1, 32'h20, 32'hAB, 3'b000, 0, 32'hDEADBEEF, 1, 0, 0, 1);
        tbl[10] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,  32'h0,  3'b000, 0, 32'hDEADBEEF, 0, 0, 0, 0);

        do_reset();
        @(posedge clk); #1;
        chk("reset exec", 32'(o_mem_exec), 0);
        chk("reset mem_addr", o_mem_addr, 0);
        chk("reset acks", {28'd0, o_if_ack, o_if_err, o_d_ack, o_d_err}, 0);
        chk("reset rdata", o_if_rdata | o_d_rdata, 0);
        chk("reset grant_d", 32'(o_grant_d), 0);

        // Fetch read, stray fin while idle, then a store that drops its req.
        i_if_addr = 32'h10; i_if_sel = 3'b010;
        i_d_we = 1'b1; i_d_addr = 32'h20; i_d_wdata = 32'hAB; i_d_sel = 3'b000;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            i_if_req = tbl[k].if_req; i_d_req = tbl[k].d_req;
            tb_fin = tbl[k].fin; tb_mdata = tbl[k].mdata;
            @(posedge clk); #1;
            chk($sformatf("vec%0d exec", k), 32'(o_mem_exec), 32'(tbl[k].exec));
            chk($sformatf("vec%0d if_ack", k), 32'(o_if_ack), 32'(tbl[k].if_ack));
            chk($sformatf("vec%0d if_rdata", k), o_if_rdata, tbl[k].if_rd);
            chk($sformatf("vec%0d d_ack", k), 32'(o_d_ack), 32'(tbl[k].d_ack));
            chk($sformatf("vec%0d errs", k), {30'd0, o_if_err, o_d_err}, {31'd0, tbl[k].d_err});
            chk($sformatf("vec%0d d_rdata", k), o_d_rdata, tbl[k].d_rd);
            chk($sformatf("vec%0d grant_d", k), 32'(o_grant_d), 32'(tbl[k].gd));
            if (tbl[k].exec) begin
                chk($sformatf("vec%0d mem_we", k), 32'(o_mem_we), 32'(tbl[k].mwe));
                chk($sformatf("vec%0d mem_addr", k), o_mem_addr, tbl[k].maddr);
                chk($sformatf("vec%0d mem_data", k), o_mem_data, tbl[k].mdat);
                chk($sformatf("vec%0d mem_sel", k), 32'(o_mem_sel), 32'(tbl[k].msel));
            end
        end
        @(negedge clk);
        tb_fin = 1'b0;

        // Both ports held from reset: d, if, d, if with acks 4 cycles apart.
        do_reset();
        mem_en = 1'b1; mem_lat_rand = 1'b0; mm_lat = 3;
        i_if_addr = 32'h104; i_if_sel = 3'b101;
        i_d_addr = 32'h108; i_d_we = 1'b0; i_d_sel = 3'b011;
        @(negedge clk);
        i_if_req = 1'b1; i_d_req = 1'b1;
        t0 = cyc + 1;
        got = 0;
        for (int k = 0; k < 40 && got < 4; k++) begin
            @(posedge clk); #1;
            if (o_if_ack || o_d_ack) begin
                a_cyc[got] = cyc; a_port[got] = o_d_ack; a_gd[got] = o_grant_d;
                a_rdv[got] = o_d_ack ? o_d_rdata : o_if_rdata;
                got++;
            end
        end
        @(negedge clk);
        i_if_req = 1'b0; i_d_req = 1'b0;
        chk("tie acks seen", 32'(got), 4);
        for (int i = 0; i < got; i++) begin
            chk($sformatf("tie%0d port", i), 32'(a_port[i]), 32'(i % 2 == 0));
            chk($sformatf("tie%0d cycle", i), 32'(a_cyc[i] - t0), 32'(3 + 4 * i));
            chk($sformatf("tie%0d grant_d", i), 32'(a_gd[i]), 32'(i % 2 == 0));
            chk($sformatf("tie%0d rdata", i), a_rdv[i], (i % 2 == 0) ? ref_arr[2] : ref_arr[1]);
        end
        repeat (3) @(negedge clk);

        // Successful data load, then a dead memory forces the timeout path.
        do_reset();
        i_d_addr = 32'h10C; i_d_we = 1'b0;
        @(negedge clk);
        i_d_req = 1'b1;
        ackc = -1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (o_d_ack) begin
                ackc = cyc; a_rd = o_d_rdata; a_err = o_d_err;
                break;
            end
        end
        @(negedge clk);
        i_d_req = 1'b0;
        chk("load ack seen", 32'(ackc >= 0), 1);
        chk("load rdata", a_rd, ref_arr[3]);
        chk("load err", 32'(a_err), 0);
        repeat (2) @(negedge clk);
        mem_dead = 1'b1;
        i_d_req = 1'b1;
        t0 = cyc + 1;
        @(negedge clk);
        i_d_req = 1'b0;
        ackc = -1; ex15 = 1'b0; a_ex = 1'b1; a_err = 1'b0; a_rd = 32'hFFFF_FFFF;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (cyc == t0 + 15) ex15 = o_mem_exec;
            if (o_d_ack) begin
                ackc = cyc; a_err = o_d_err; a_rd = o_d_rdata; a_ex = o_mem_exec;
                break;
            end
        end
        chk("timeout exec before", 32'(ex15), 1);
        chk("timeout latency", 32'(ackc - t0), 16);
        chk("timeout err", 32'(a_err), 1);
        chk("timeout rdata", a_rd, 0);
        chk("timeout exec after", 32'(a_ex), 0);
        @(posedge clk); #1;
        chk("timeout ack pulse", {30'd0, o_d_ack, o_d_err}, 0);
        mem_dead = 1'b0;

        // Asynchronous reset in the middle of a busy fetch.
        @(negedge clk);
        i_if_addr = 32'h110;
        i_if_req = 1'b1;
        @(posedge clk); @(posedge clk); #2;
        chk("pre-reset exec", 32'(o_mem_exec), 1);
        i_reset_n = 1'b0;
        i_if_req = 1'b0;
        #1;
        chk("async reset exec", 32'(o_mem_exec), 0);
        chk("async reset acks", {30'd0, o_if_ack, o_d_ack}, 0);
        chk("async reset grant_d", 32'(o_grant_d), 0);
        @(negedge clk);
        i_reset_n = 1'b1;
        seen_exec = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            seen_exec |= o_mem_exec;
        end
        chk("no exec after reset", 32'(seen_exec), 0);

        // Randomized traffic with random memory latency.
        do_reset();
        mem_lat_rand = 1'b1; mon_en = 1'b1;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; idle_c[p] = p; wait_c[p] = 0; n_done[p] = 0;
            last_rd[p] = '0; r_addr[p] = '0; r_wdata[p] = '0; r_we[p] = 1'b0; r_sel[p] = '0;
        end
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            ack[0] = o_if_ack; ack[1] = o_d_ack;
            for (int p = 0; p < 2; p++) begin
                chk("ack without request", 32'(ack[p] & ~pend[p]), 0);
                if (pend[p] && ack[p]) begin
                    idx = r_addr[p][5:2];
                    rdv = (p == 1) ? o_d_rdata : o_if_rdata;
                    exp_rd = r_we[p] ? last_rd[p] : ref_arr[idx];
                    chk("rnd mem_addr", rec_addr, r_addr[p]);
                    chk("rnd mem_we", 32'(rec_we), 32'(r_we[p]));
                    chk("rnd mem_data", rec_data, (p == 1) ? r_wdata[p] : 32'h0);
                    chk("rnd mem_sel", 32'(rec_sel), 32'(r_sel[p]));
                    chk("rnd grant_d", 32'(o_grant_d), 32'(p == 1));
                    chk("rnd rdata", rdv, exp_rd);
                    if (r_we[p]) ref_arr[idx] = r_wdata[p];
                    last_rd[p] = exp_rd;
                    wait_c[p] = 0;
                    n_done[p]++;
                end else if (pend[p] && ack[1 - p]) begin
                    wait_c[p]++;
                    chk("round robin wait", 32'(wait_c[p] <= 1), 1);
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (pend[p] && ack[p]) begin
                    if ($urandom_range(0, 1) == 1) new_req(p);
                    else begin
                        pend[p] = 1'b0;
                        idle_c[p] = int'($urandom_range(0, 3));
                    end
                end else if (!pend[p]) begin
                    if (idle_c[p] == 0) new_req(p);
                    else idle_c[p]--;
                end
            end
            i_if_req = pend[0]; i_if_addr = r_addr[0]; i_if_sel = r_sel[0];
            i_d_req = pend[1]; i_d_we = r_we[1]; i_d_addr = r_addr[1];
            i_d_wdata = r_wdata[1]; i_d_sel = r_sel[1];
        end
        i_if_req = 1'b0; i_d_req = 1'b0;
        repeat (8) @(negedge clk);
        mon_en = 1'b0;
        chk("random progress", 32'(n_done[0] > 20 && n_done[1] > 20), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
